wdt_tick_supervisor: RTL

- Downstream consumer of the 1 Hz tick from the watchdog pulse generator (the 1 s pulse block).
- Counts elapsed seconds since the last software kick.
- Raises a warning level before timeout, then a one-cycle bite pulse and a sticky expired flag at timeout.
- Output feeds the system reset controller.

---
 rtl/wdt_tick_supervisor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/wdt_tick_supervisor.sv
// wdt_tick_supervisor
// Counts 1 Hz ticks since the last software kick, raises warn ahead of the
// timeout, then fires a one-cycle bite and latches expired until reset.
// Optional kick-window check is compiled in with `define WDT_WINDOW_EN.
module wdt_tick_supervisor #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_1s,
    input  logic          enable,
    input  logic          kick,
    input  logic [TW-1:0] timeout_s,
    input  logic [TW-1:0] warn_s,
    input  logic [TW-1:0] window_s,
    output logic [TW-1:0] count,
    output logic          warn,
    output logic          bite,
    output logic          expired,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_WARN    = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_n;
    logic [TW-1:0] count_q;
    logic [TW-1:0] count_n;
    logic [TW-1:0] timeout_q;
    logic [TW-1:0] warn_q;
    logic [TW-1:0] wp;
    logic          bite_n;
    logic          arm;
    logic          window_violation;

`ifdef WDT_WINDOW_EN
    logic [TW-1:0] window_q;

    // Kick window latch, captured together with the other config on arming
    always_ff @(posedge clk) begin
        if (rst) begin
            window_q <= '0;
        end else if (arm) begin
            window_q <= window_s;
        end
    end

    // A kick that arrives before the window opens counts as a violation
    always_comb begin
        window_violation = (window_q != '0) && (count_q < window_q);
    end
`else
    logic window_unused;
    assign window_unused = ^window_s;

    // Without the window feature every kick in RUN/WARN is legal
    always_comb begin
        window_violation = 1'b0;
    end
`endif

    // Warning point: seconds into the period where WARN begins
    always_comb begin
        wp = (warn_q < timeout_q) ? (timeout_q - warn_q) : '0;
    end

    // Next-state, next-count and bite decode
    always_comb begin
        state_n = state_q;
        count_n = count_q;
        bite_n  = 1'b0;
        arm     = 1'b0;
        case (state_q)
            S_IDLE: begin
                count_n = '0;
                if (enable) begin
                    state_n = S_RUN;
                    arm     = 1'b1;
                end
            end
            S_RUN, S_WARN: begin
                if (!enable) begin
                    state_n = S_IDLE;
                    count_n = '0;
                end else if (kick) begin
                    if (window_violation) begin
                        state_n = S_EXPIRED;
                        bite_n  = 1'b1;
                    end else begin
                        state_n = S_RUN;
                        count_n = '0;
                    end
                end else begin
                    // count never exceeds timeout_q, so +1 cannot wrap here
                    if (tick_1s) begin
                        count_n = count_q + 1'b1;
                    end
                    if (tick_1s && (count_n == timeout_q)) begin
                        state_n = S_EXPIRED;
                        bite_n  = 1'b1;
                    end else if ((state_q == S_RUN) && (count_n >= wp)) begin
                        state_n = S_WARN;
                    end
                end
            end
            S_EXPIRED: begin
                state_n = S_EXPIRED;
            end
            default: begin
                state_n = S_IDLE;
                count_n = '0;
            end
        endcase
    end

    // State, counter and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            warn    <= 1'b0;
            bite    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            warn    <= (state_n == S_WARN);
            bite    <= bite_n;
            expired <= (state_n == S_EXPIRED);
        end
    end

    // Timeout and warning lead time are frozen for the whole armed period
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= '0;
            warn_q    <= '0;
        end else if (arm) begin
            timeout_q <= (timeout_s == '0) ? TW'(1) : timeout_s;
            warn_q    <= warn_s;
        end
    end

    assign count = count_q;
    assign state = state_q;

endmodule
